// File: rtl/clk_div_gen_if.sv
// Configuration channel for clk_div_gen: one request slot carrying target channel, ratio and phase.
// The master drives the request fields; the slave returns ready when its slot is free.
interface clk_div_gen_if #(
  parameter int unsigned DIV_W = 8
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic [2:0]       cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [DIV_W-1:0] cfg_phase;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    output cfg_phase,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    input  cfg_phase,
    output cfg_ready
  );

endinterface

// File: rtl/clk_div_gen.sv
// Multi-channel clock-enable generator with period-boundary reconfiguration and a lock monitor.
// Optional macro CLKGEN_PHASE_EN: cfg_phase becomes the counter load value when an update applies.
module clk_div_gen #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEF_DIV     = 50,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic              refclk,
  input  logic              reset_n,
  clk_div_gen_if.slave      cfg,
  input  logic              sync_i,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] clk_out_o,
  output logic              extlock_o
);

  localparam int unsigned      LkW    = $clog2(LOCK_CYCLES + 1);
  localparam logic [LkW-1:0]   LkMax  = LkW'(LOCK_CYCLES);
  localparam logic [DIV_W-1:0] DivOne = DIV_W'(1);
  localparam logic [DIV_W-1:0] DivDef = DIV_W'(DEF_DIV);

  // Request slot: StReset holds ready low until the first clock after reset release.
  typedef enum logic [1:0] {
    StReset,
    StIdle,
    StPend
  } cfg_st_e;

  cfg_st_e st_q, st_d;

  logic [NUM_CH-1:0][DIV_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][DIV_W-1:0] div_q, div_d;
  logic [NUM_CH-1:0]            wrap;
  logic [NUM_CH-1:0]            apply;
  logic [NUM_CH-1:0]            tick_q, tick_d;
  logic [NUM_CH-1:0]            clk_q, clk_d;

  logic [2:0]       pend_ch_q, pend_ch_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic [DIV_W-1:0] load_val;

  logic [LkW-1:0] lk_q, lk_d;
  logic           ext_q, ext_d;

  logic xfer;
  logic ch_ok;
  logic accept;
  logic any_apply;
  logic lk_clr;
  logic rdy;

  // ---------------------------------------------------------------------------------------------
  // Configuration handshake
  // ---------------------------------------------------------------------------------------------
  assign xfer   = cfg.cfg_valid & rdy;
  assign ch_ok  = 32'(cfg.cfg_ch) < NUM_CH;
  assign accept = xfer & ch_ok;

  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      st_q <= StReset;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StReset: st_d = StIdle;
      StIdle:  if (accept) st_d = StPend;
      StPend:  if (any_apply) st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  always_comb begin
    rdy = 1'b0;
    unique case (st_q)
      StIdle:  rdy = 1'b1;
      default: rdy = 1'b0;
    endcase
  end

  assign cfg.cfg_ready = rdy;

  // Out-of-range channels complete the handshake but never reach the slot.
  always_comb begin
    pend_ch_d  = pend_ch_q;
    pend_div_d = pend_div_q;
    if (accept) begin
      pend_ch_d  = cfg.cfg_ch;
      pend_div_d = (cfg.cfg_div == '0) ? DivOne : cfg.cfg_div;
    end
  end

  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      pend_ch_q  <= '0;
      pend_div_q <= DivOne;
    end else begin
      pend_ch_q  <= pend_ch_d;
      pend_div_q <= pend_div_d;
    end
  end

`ifdef CLKGEN_PHASE_EN
  logic [DIV_W-1:0] pend_phase_q;

  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      pend_phase_q <= '0;
    end else if (accept) begin
      pend_phase_q <= cfg.cfg_phase;
    end
  end

  // One comparator serves all channels: only one update can be pending at a time.
  assign load_val = (pend_phase_q < pend_div_q) ? pend_phase_q : '0;
`else
  logic unused_phase;

  assign unused_phase = ^cfg.cfg_phase;
  assign load_val     = '0;
`endif

  // ---------------------------------------------------------------------------------------------
  // Channel counters
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wrap[i]  = (cnt_q[i] == div_q[i] - DivOne);
      apply[i] = (st_q == StPend) && (pend_ch_q == 3'(i)) && (wrap[i] || sync_i);
    end
  end

  assign any_apply = |apply;

  // sync takes priority over a normal wrap and forces every counter to zero.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      div_d[i] = div_q[i];
      cnt_d[i] = cnt_q[i] + DivOne;
      if (apply[i]) begin
        div_d[i] = pend_div_q;
        cnt_d[i] = sync_i ? '0 : load_val;
      end else if (sync_i || wrap[i]) begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= DivDef;
      end
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      tick_d[i] = wrap[i];
      clk_d[i]  = (cnt_q[i] < (div_q[i] >> 1));
    end
  end

  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q <= '0;
      clk_q  <= '0;
    end else begin
      tick_q <= tick_d;
      clk_q  <= clk_d;
    end
  end

  assign tick_o    = tick_q;
  assign clk_out_o = clk_q;

  // ---------------------------------------------------------------------------------------------
  // Lock monitor
  // ---------------------------------------------------------------------------------------------
  assign lk_clr = sync_i | any_apply;

  // extlock drops on the same edge that clears the counter, not one cycle later.
  always_comb begin
    lk_d = lk_q;
    if (lk_clr) begin
      lk_d = '0;
    end else if (lk_q != LkMax) begin
      lk_d = lk_q + LkW'(1);
    end
    ext_d = !lk_clr && (lk_q == LkMax);
  end

  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      lk_q  <= '0;
      ext_q <= 1'b0;
    end else begin
      lk_q  <= lk_d;
      ext_q <= ext_d;
    end
  end

  assign extlock_o = ext_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: outputs are logged per cycle after each edge, then checked
// against hand-computed cycle indices counted from reset release.
module tb_clk_div_gen;

  localparam int HLEN = 512;

`ifdef CLKGEN_PHASE_EN
  localparam int PH = 7;
  localparam int W4 = 233;
`else
  localparam int PH = 0;
  localparam int W4 = 240;
`endif

  logic       refclk  = 1'b0;
  logic       reset_n = 1'b0;
  logic       sync_i  = 1'b0;
  logic [1:0] tick_o;
  logic [1:0] clk_out_o;
  logic       extlock_o;

  clk_div_gen_if #(.DIV_W(8)) cfg_if ();

  clk_div_gen #(
    .NUM_CH     (2),
    .DIV_W      (8),
    .DEF_DIV    (50),
    .LOCK_CYCLES(16)
  ) dut (
    .refclk   (refclk),
    .reset_n  (reset_n),
    .cfg      (cfg_if),
    .sync_i   (sync_i),
    .tick_o   (tick_o),
    .clk_out_o(clk_out_o),
    .extlock_o(extlock_o)
  );

  always #5 refclk = ~refclk;

  logic [1:0] tk_h [HLEN];
  logic [1:0] ck_h [HLEN];
  logic       lk_h [HLEN];
  logic       rd_h [HLEN];

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;
  int r0       = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
    cyc++;
    if (cyc < HLEN) begin
      tk_h[cyc] = tick_o;
      ck_h[cyc] = clk_out_o;
      lk_h[cyc] = extlock_o;
      rd_h[cyc] = cfg_if.cfg_ready;
    end
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  // One-cycle request; the accepting edge is the next logged cycle.
  task automatic send(input int ch, input int dv, input int ph);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 3'(ch);
    cfg_if.cfg_div   = 8'(dv);
    cfg_if.cfg_phase = 8'(ph);
    step();
    cfg_if.cfg_valid = 1'b0;
  endtask

  function automatic int cnt_hi(input bit use_clk, input int ch, input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++) begin
      n += use_clk ? int'(ck_h[k][ch]) : int'(tk_h[k][ch]);
    end
    return n;
  endfunction

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_phase = '0;
    repeat (3) @(posedge refclk);
    #1;
    check_eq("rst_tick", int'(tick_o), 0);
    check_eq("rst_clk", int'(clk_out_o), 0);
    check_eq("rst_lock", int'(extlock_o), 0);
    check_eq("rst_rdy", int'(cfg_if.cfg_ready), 0);
    reset_n = 1'b1;
    check_eq("rel_rdy", int'(cfg_if.cfg_ready), 0);

    // Default 50-cycle operation, then ch1 -> div 4 requested mid-period.
    run_to(101);
    send(1, 4, 0);
    run_to(180);
    send(0, 10, 7);
    run_to(230);
    send(0, 0, 7);
    run_to(250);
    send(0, 1, 0);
    run_to(260);
    send(5, 3, 0);
    run_to(280);
    send(1, 8, 0);

    check_eq("pre_rst_tick0", int'(tick_o[0]), 1);
    check_eq("pre_rst_lock", int'(extlock_o), 1);
    reset_n = 1'b0;
    #1;
    check_eq("arst_tick", int'(tick_o), 0);
    check_eq("arst_clk", int'(clk_out_o), 0);
    check_eq("arst_lock", int'(extlock_o), 0);
    check_eq("arst_rdy", int'(cfg_if.cfg_ready), 0);
    run_to(285);
    reset_n = 1'b1;
    r0 = cyc;
    check_eq("rel2_rdy", int'(cfg_if.cfg_ready), 0);

    run_to(386);
    send(1, 8, 0);
    run_to(390);
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    run_to(450);

    // Reset default
    check_eq("def_rdy1", int'(rd_h[1]), 1);
    check_eq("def_clk0_1", int'(ck_h[1][0]), 1);
    check_eq("def_clk0_hi", cnt_hi(1, 0, 1, 50), 25);
    check_eq("def_tk0_none", cnt_hi(0, 0, 1, 49), 0);
    check_eq("def_tk0_50", int'(tk_h[50][0]), 1);
    check_eq("def_tk0_100", int'(tk_h[100][0]), 1);
    check_eq("def_tk0_cnt", cnt_hi(0, 0, 1, 100), 2);
    check_eq("def_tk1_50", int'(tk_h[50][1]), 1);
    check_eq("def_lock16", int'(lk_h[16]), 0);
    check_eq("def_lock17", int'(lk_h[17]), 1);

    // ch1 reconfigure to div 4
    check_eq("rc_rdy102", int'(rd_h[102]), 0);
    check_eq("rc_rdy149", int'(rd_h[149]), 0);
    check_eq("rc_rdy150", int'(rd_h[150]), 1);
    check_eq("rc_old_period", cnt_hi(0, 1, 101, 150), 1);
    check_eq("rc_tk1_150", int'(tk_h[150][1]), 1);
    check_eq("rc_tk1_154", int'(tk_h[154][1]), 1);
    check_eq("rc_tk1_158", int'(tk_h[158][1]), 1);
    check_eq("rc_tk1_cnt", cnt_hi(0, 1, 151, 158), 2);
    check_eq("rc_clk1_hi", cnt_hi(1, 1, 151, 158), 4);
    check_eq("rc_lock149", int'(lk_h[149]), 1);
    check_eq("rc_lock150", int'(lk_h[150]), 0);
    check_eq("rc_lock166", int'(lk_h[166]), 0);
    check_eq("rc_lock167", int'(lk_h[167]), 1);

    // ch0 div 10, phase 7 (ignored without the phase macro)
    check_eq("ph_rdy181", int'(rd_h[181]), 0);
    check_eq("ph_rdy199", int'(rd_h[199]), 0);
    check_eq("ph_rdy200", int'(rd_h[200]), 1);
    check_eq("ph_tk0_200", int'(tk_h[200][0]), 1);
    check_eq("ph_gap", cnt_hi(0, 0, 201, 209 - PH), 0);
    check_eq("ph_first", int'(tk_h[210 - PH][0]), 1);
    check_eq("ph_second", int'(tk_h[220 - PH][0]), 1);
    check_eq("ph_cnt", cnt_hi(0, 0, 201, 220 - PH), 2);
    check_eq("ph_lock200", int'(lk_h[200]), 0);

    // cfg_div = 0 clamps to 1; then explicit div 1; then out-of-range channel
    check_eq("d0_tk_w", int'(tk_h[W4][0]), 1);
    check_eq("d0_tk_const", cnt_hi(0, 0, W4 + 1, W4 + 10), 10);
    check_eq("d0_clk_const", cnt_hi(1, 0, W4 + 1, W4 + 10), 0);
    check_eq("d1_rdy251", int'(rd_h[251]), 0);
    check_eq("d1_rdy252", int'(rd_h[252]), 1);
    check_eq("ch5_rdy261", int'(rd_h[261]), 1);
    check_eq("ch5_tk0", cnt_hi(0, 0, 262, 270), 9);
    check_eq("ch5_tk1_cnt", cnt_hi(0, 1, 262, 277), 4);
    check_eq("ch5_lock268", int'(lk_h[268]), 0);
    check_eq("ch5_lock269", int'(lk_h[269]), 1);

    // Reset with an update pending: both channels resume at 50
    check_eq("r2_rdy", int'(rd_h[r0 + 1]), 1);
    check_eq("r2_tk1_50", int'(tk_h[r0 + 50][1]), 1);
    check_eq("r2_tk1_100", int'(tk_h[r0 + 100][1]), 1);
    check_eq("r2_tk1_cnt", cnt_hi(0, 1, r0 + 1, r0 + 100), 2);
    check_eq("r2_tk0_cnt", cnt_hi(0, 0, r0 + 1, r0 + 100), 2);
    check_eq("r2_clk1_hi", cnt_hi(1, 1, r0 + 1, r0 + 50), 25);
    check_eq("r2_lock16", int'(lk_h[r0 + 16]), 0);
    check_eq("r2_lock17", int'(lk_h[r0 + 17]), 1);

    // sync with ch1 -> div 8 pending
    check_eq("sy_rdy387", int'(rd_h[387]), 0);
    check_eq("sy_rdy390", int'(rd_h[390]), 0);
    check_eq("sy_rdy391", int'(rd_h[391]), 1);
    check_eq("sy_lock390", int'(lk_h[390]), 1);
    check_eq("sy_lock391", int'(lk_h[391]), 0);
    check_eq("sy_lock407", int'(lk_h[407]), 0);
    check_eq("sy_lock408", int'(lk_h[408]), 1);
    check_eq("sy_tk0_quiet", cnt_hi(0, 0, 392, 440), 0);
    check_eq("sy_tk0_441", int'(tk_h[441][0]), 1);
    check_eq("sy_tk1_cnt", cnt_hi(0, 1, 391, 406), 1);
    check_eq("sy_tk1_399", int'(tk_h[399][1]), 1);
    check_eq("sy_tk1_407", int'(tk_h[407][1]), 1);
    check_eq("sy_clk1_392", int'(ck_h[392][1]), 1);
    check_eq("sy_clk1_396", int'(ck_h[396][1]), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Parametrised multi-channel clock-enable generator and lock monitor, the successor to the fixed two-output PLL wrapper. It runs on the PLL output clock and derives `NUM_CH` divided strobes and square waves with divide ratios programmable at run time. Channel updates are applied glitch-free at period boundaries. An `extlock` status asserts once all channels have run a programmable number of cycles without reconfiguration.

## Interface
- `NUM_CH`, default 2: number of output channels, 1..8.
- `DIV_W`, default 8: divider and phase width in bits.
- `DEF_DIV`, default 50: reset divide ratio, all channels; must be ≥1.
- `LOCK_CYCLES`, default 16: quiet cycles before `extlock`; must be ≥1.

- `refclk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `cfg_valid` in 1: configuration request.
- `cfg_ready` out 1: configuration slot free.
- `cfg_ch` in 3: target channel index.
- `cfg_div` in DIV_W: new divide ratio.
- `cfg_phase` in DIV_W: counter load value at apply.
- `sync` in 1: realign all channels.
- `tick` out NUM_CH: one-cycle strobe per channel period.
- `clk_out` out NUM_CH: divided square wave.
- `extlock` out 1: outputs stable.

## Operation
- Per channel:
  - State is `cnt` and `div`, both DIV_W bits wide.
  - `cnt` counts 0..div-1, then wraps to 0.
- Outputs are registered and derived from `cnt`:
  - `tick[i]` = 1 when `cnt == div-1`.
  - `clk_out[i]` = 1 when `cnt < div>>1`.
  - `div` = 1: `tick` held 1 and `clk_out` held 0.
- Config handshake:
  - A transfer occurs on a cycle where `cfg_valid && cfg_ready` is high.
  - The accepted request is latched as a single pending update, and `cfg_ready` drops.
  - `cfg_div` = 0 clamps to 1.
  - `cfg_ch` ≥ NUM_CH is accepted and discarded; `cfg_ready` does not drop.
- Apply:
  - A pending update applies on the target channel's wrap cycle (`cnt == div-1`).
  - Next cycle: `div` ← new value; `cnt` ← `cfg_phase` if `cfg_phase` < new div, else 0.
  - The current period always completes, so no shortened or runt pulse is produced.
  - `cfg_ready` returns to 1 on the cycle after apply.
- `sync`:
  - On `sync` = 1, every channel loads `cnt` ← 0 next cycle.
  - A pending update for a channel is applied in the same cycle instead of waiting for wrap.
  - `sync` has priority over normal wrap.
- Lock monitor:
  - Counter `lk_cnt` counts up to LOCK_CYCLES, width clog2(LOCK_CYCLES+1).
  - Cleared by reset, any apply, or `sync`.
  - Saturates at LOCK_CYCLES.
  - `extlock` = (`lk_cnt` == LOCK_CYCLES), registered.
- Reset (async assert, sync release internally not required):
  - `cnt` = 0, `div` = DEF_DIV, pending cleared.
  - `tick` = 0, `clk_out` = 0, `extlock` = 0, `cfg_ready` = 0.
  - `cfg_ready` rises on the first clock after `reset_n` is released.
- Reset mid-operation discards any pending update; channels restart from DEF_DIV.

## Timing
- Config to first new-ratio tick:
  - Acceptance at cycle A; the target wraps at cycle W ≥ A+1.
  - The new period starts at W+1, so the first new `tick` appears at W + 1 + (newdiv-1-phase).
- `cfg_ready` low from A+1 through W; high again at W+1.
- `sync` at cycle S: `cnt` = 0 at S+1; `tick` for `div` = 1 continuous.
- `extlock`:
  - Rises LOCK_CYCLES+1 cycles after the last apply or `sync`.
  - Falls the cycle after an apply or `sync`.
- Output registers add one cycle from `cnt` state to `tick` and `clk_out`.

## Configuration
- `CLKGEN_PHASE_EN` defined: `cfg_phase` is honoured at apply, as above.
- `CLKGEN_PHASE_EN` undefined:
  - The `cfg_phase` port remains but is ignored.
  - Every apply loads `cnt` ← 0; phase logic and comparator are not synthesised.

## Test plan
- Reset default: NUM_CH = 2, DEF_DIV = 50, release `reset_n`. Required response:
  - `tick[0]` period 50 cycles.
  - `clk_out[0]` high 25 / low 25.
  - `extlock` rises 17 cycles after release.
- Reconfigure ch1: write div = 4 mid-period. Required response:
  - The old 50-cycle period completes intact.
  - Then 4-cycle period with 2/2 duty.
  - `cfg_ready` low until the wrap; `extlock` drops, then rises 17 cycles later.
- Phase (macro on): write div = 10, phase = 7 to ch0. Required response:
  - First new `tick` 2 cycles after apply, then every 10.
  - Macro off, same stimulus: first new `tick` 9 cycles after apply.
- Edge values: `cfg_div` = 0 on ch0, then div = 1. Required response:
  - `tick[0]` constant 1, `clk_out[0]` constant 0.
  - `cfg_ch` = 5 is accepted with no state change and `cfg_ready` stays 1.
- `sync` with pending update: pending div = 8 on ch1, assert `sync` early in a 50-cycle period. Required response:
  - Both channels restart at `cnt` = 0 the next cycle; ch1 at div 8 immediately.
  - `extlock` cleared.
- Reset mid-pending: drop `reset_n` while an update is pending. Required response:
  - All outputs 0 asynchronously.
  - After release, both channels resume at div 50 and the pending update is lost.
